alu_rsp_core: RTL and testbench

Sequential ALU responder on the receiving end of the `alu_intf` protocol: it consumes `inp1`/`inp2`/`op_code` from the stimulus side and returns a registered `outp` to the output monitor. A valid/ready handshake is added on the request side and a one-cycle `out_valid` strobe on the result side. Add, subtract and AND complete in one cycle. Multiply is iterative shift-add unless the fast-multiply option is compiled in. The block is the DUT bound under the team's ALU UVM environment.

---
 rtl/alu_rsp_core.sv | 112 +++++++++++
 tb/tb_alu_rsp_core.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_rsp_core.sv
// alu_rsp_core: valid/ready ALU responder (ADD/SUB/MUL/AND) with registered 2N-bit result and one-cycle out_valid strobe
// Ports: clk, reset (sync, active-high); in_valid/in_ready request handshake;
//   inp1/inp2 N-bit unsigned operands; op_code 00 ADD, 01 SUB, 10 MUL, 11 AND;
//   outp 2N-bit result register; out_valid one-cycle "outp is new" strobe.
// Define ALU_RSP_FAST_MUL_EN for a single-cycle combinational multiply;
//   otherwise MUL is an N-cycle shift-add that drops in_ready while busy.
module alu_rsp_core #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   inp1,
  input  logic [N-1:0]   inp2,
  input  logic [1:0]     op_code,
  output logic [2*N-1:0] outp,
  output logic           out_valid
);
  localparam int W = 2 * N;
  logic [W-1:0] a, b, res, mul_res, outp_q, outp_d;
  logic         out_valid_q, out_valid_d;
  assign a = {{N{1'b0}}, inp1};
  assign b = {{N{1'b0}}, inp2};
  assign outp = outp_q;
  assign out_valid = out_valid_q;
`ifdef ALU_RSP_FAST_MUL_EN
  assign mul_res = a * b;
`else
  // The iterative path never takes this value; MUL leaves IDLE instead.
  assign mul_res = '0;
`endif
  always_comb
    res = op_code == 2'b00 ? a + b :
          op_code == 2'b01 ? a - b :
          op_code == 2'b11 ? a & b : mul_res;
`ifdef ALU_RSP_FAST_MUL_EN
  assign in_ready = 1'b1;
  always_comb begin
    outp_d = in_valid ? res : outp_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      outp_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      outp_q <= outp_d;
      out_valid_q <= out_valid_d;
    end
  end
`else
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  mcand_q, mcand_d, acc_q, acc_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign in_ready = state_q == IDLE;
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    outp_d = outp_q;
    out_valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (in_valid && op_code == 2'b10) begin
        state_d = MUL;
        mcand_d = a;
        mplier_d = inp2;
        acc_d = '0;
        cnt_d = '0;
      end else if (in_valid) begin
        outp_d = res;
        out_valid_d = 1'b1;
      end
    end else begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + 1'b1;
      // Last partial product is folded in on the same edge the result is published.
      if (cnt_q == CW'(N - 1)) begin
        outp_d = acc_d;
        out_valid_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      outp_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      outp_q <= outp_d;
      out_valid_q <= out_valid_d;
    end
  end
`endif
endmodule

// File: tb/tb_alu_rsp_core.sv
// tb_alu_rsp_core: directed stimulus, per-cycle model comparison plus literal result checks
module tb_alu_rsp_core;
  localparam int N = 4;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [N-1:0] inp1 = '0, inp2 = '0;
  logic [1:0] op_code = '0;
  logic in_ready, out_valid;
  logic [2*N-1:0] outp;
  int checks = 0, failures = 0;

  alu_rsp_core #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inp1(inp1), .inp2(inp2), .op_code(op_code), .outp(outp), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: plain arithmetic on the operands, with a countdown for the busy multiply.
  int pend = 0;
  logic [7:0] pend_val = '0, m_outp = '0;
  logic m_valid = 1'b0, m_ready = 1'b1;
  bit m_ok = 0;
  always @(posedge clk) begin
    int ai, bi;
    logic [7:0] r;
    ai = int'(inp1);
    bi = int'(inp2);
    if (reset) begin
      m_outp = 0; m_valid = 0; m_ready = 1; pend = 0; m_ok = 1;
    end else begin
      m_valid = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin m_outp = pend_val; m_valid = 1; m_ready = 1; end
      end else if (in_valid && m_ready) begin
        case (op_code)
          2'b00: r = 8'(ai + bi);
          2'b01: r = 8'(ai - bi);
          2'b10: r = 8'(ai * bi);
          default: r = 8'(ai & bi);
        endcase
`ifdef ALU_RSP_FAST_MUL_EN
        m_outp = r; m_valid = 1;
`else
        if (op_code == 2'b10) begin pend = N; pend_val = r; m_ready = 0; end
        else begin m_outp = r; m_valid = 1; end
`endif
      end
    end
  end

  always @(negedge clk)
    if (m_ok) begin
      chk("cmp_outp", 32'(outp), 32'(m_outp));
      chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cmp_in_ready", 32'(in_ready), 32'(m_ready));
    end

  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y, input logic [1:0] op);
    in_valid = v; inp1 = x; inp2 = y; op_code = op;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [7:0] eo, input logic ev, input logic er);
    chk({nm, "_outp"}, 32'(outp), 32'(eo));
    chk({nm, "_valid"}, 32'(out_valid), 32'(ev));
    chk({nm, "_ready"}, 32'(in_ready), 32'(er));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 0); lit("idle", 8'h00, 0, 1); end
    drive(1, 4'hF, 4'hF, 2'b00); lit("add_ff", 8'h1E, 1, 1);
    drive(1, 4'h3, 4'h5, 2'b01); lit("sub_3_5", 8'hFE, 1, 1);
    drive(0, 0, 0, 0);           lit("hold", 8'hFE, 0, 1);
    drive(1, 4'hC, 4'hA, 2'b11); lit("and_c_a", 8'h08, 1, 1);
    drive(1, 4'h0, 4'hF, 2'b01); lit("sub_0_f", 8'hF1, 1, 1);
`ifdef ALU_RSP_FAST_MUL_EN
    drive(1, 4'hF, 4'hF, 2'b10); lit("fmul_ff", 8'hE1, 1, 1);
    drive(1, 4'h2, 4'h3, 2'b10); lit("fmul_23", 8'h06, 1, 1);
    drive(0, 0, 0, 0);           lit("fmul_done", 8'h06, 0, 1);
`else
    drive(1, 4'hF, 4'hF, 2'b10); lit("mul_busy0", 8'hF1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'h1, 4'h1, 2'b00);
      if (i < 3) lit("mul_busy", 8'hF1, 0, 0);
      else lit("mul_ff", 8'hE1, 1, 1);
    end
    drive(0, 0, 0, 0);           lit("mul_after", 8'hE1, 0, 1);
    drive(1, 4'h2, 4'h3, 2'b10);
    repeat (3) drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);           lit("mul_23", 8'h06, 1, 1);
    drive(1, 4'h7, 4'h3, 2'b10);
    drive(0, 0, 0, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0);
    reset = 1'b0;                lit("mul_abort", 8'h00, 0, 1);
    repeat (4) begin drive(0, 0, 0, 0); lit("abort_quiet", 8'h00, 0, 1); end
`endif
    reset = 1'b1;
    drive(1, 4'h2, 4'h2, 2'b00);
    reset = 1'b0;                lit("rst_prio", 8'h00, 0, 1);
    drive(1, 4'h0, 4'h0, 2'b00); lit("add_00", 8'h00, 1, 1);
    drive(1, 4'h9, 4'h6, 2'b00); lit("add_96", 8'h0F, 1, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
